gpi_debounce: RTL and testbench
===============================

GPI_DEBOUNCE -- requirements
Module: gpi_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of external input pins (1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a change (>=1).
REQ-003 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port address, input, 5: register select within the slot.
REQ-006 SHALL have port rd_data, output, 32: read data.
REQ-007 SHALL have port wr_data, input, 32: write data.
REQ-008 SHALL have port read, input, 1: read strobe.
REQ-009 SHALL have port write, input, 1: write strobe.
REQ-010 SHALL have port cs, input, 1: slot chip select.
REQ-011 SHALL have port data_in, input, WIDTH: asynchronous external pins, e.g. switches or buttons.
REQ-012 SHALL have port irq, output, 1: level interrupt request.

Function
REQ-013 SHALL pass data_in through a 2-flop synchronizer per bit; the second stage is sync[i].
REQ-014 SHALL keep a per-bit debounced value stable[i] and a per-bit counter cnt[i] of width clog2(DB_CYCLES+1).
REQ-015 SHALL, per bit and cycle: if sync==stable, cnt<=0; else if cnt==DB_CYCLES-1, stable<=sync and cnt<=0; else cnt<=cnt+1.
REQ-016 SHALL give a pin-to-stable latency of exactly 2+DB_CYCLES cycles for a clean level change; any glitch shorter than DB_CYCLES cycles at sync SHALL leave stable unchanged.
REQ-017 SHALL set rise[i] on the clock edge where stable[i] goes 0->1, and fall[i] where it goes 1->0; flags are sticky.
REQ-018 SHALL hold a WIDTH-bit mask register ie, read/write.
REQ-019 SHALL decode wr_en = write & cs and rd_en = read & cs.
REQ-020 SHALL implement register map: addr 0 = stable (RO); 1 = rise (W1C); 2 = fall (W1C); 3 = ie (RW, wr_data[WIDTH-1:0]); 4..31 reserved.
REQ-021 SHALL clear rise/fall bit i on a write to addr 1/2 with wr_data[i]=1; bits with wr_data[i]=0 are unaffected.
REQ-022 SHALL give set priority: a new edge on bit i in the same cycle as its W1C clear leaves the flag at 1.
REQ-023 SHALL ignore writes to addr 0 and to reserved addresses.
REQ-024 SHALL drive rd_data combinationally: selected register zero-extended to 32 bits when rd_en; 0 for reserved addresses or when rd_en=0.
REQ-025 SHALL drive irq = |((rise | fall) & ie) combinationally from registered state; no read side effects.

Reset
REQ-026 SHALL, while reset=1, immediately clear both synchronizer stages, stable, cnt, rise, fall and ie to 0, independent of clock.
REQ-027 SHALL, therefore, drive irq=0 and rd_data=0 during reset; a pin held high through reset SHALL produce rise=1 exactly 2+DB_CYCLES cycles after release.
REQ-028 SHALL abort any debounce in progress when reset asserts mid-count; no partial count survives.

Verification
REQ-029 SHALL cover: DB_CYCLES=4, data_in[0] 0->1 held -> stable[0]=1 and rise[0]=1 exactly 6 cycles later; read addr 0 -> 0x00000001.
REQ-030 SHALL cover: data_in[3] 3-cycle high pulse with DB_CYCLES=4 -> stable, rise, fall stay 0; irq stays 0.
REQ-031 SHALL cover: ie=0x0001, rise[0] set -> irq=1; write 0x1 to addr 1 -> rise=0, irq=0 next cycle; write 0x1 to addr 2 with fall=0 -> no change.
REQ-032 SHALL cover: W1C of rise[2] in the same cycle stable[2] rises -> rise[2] reads 1 afterwards.
REQ-033 SHALL cover: reset asserted between clock edges mid-count -> all registers 0 before the next edge; rd_data of addr 3 reads 0x00000000.
REQ-034 SHALL cover: cs=0 with write=1 to addr 3 -> ie unchanged; read of addr 7 -> 0x00000000.

Source files
------------

// File: rtl/gpi_debounce.sv
// -----------------------------------------------------------------------------
// gpi_debounce
//
// Debounces WIDTH asynchronous input pins (switches, buttons). Each pin goes
// through a two-flop synchronizer and then a per-bit stability counter. A
// change is accepted only after DB_CYCLES consecutive cycles of disagreement
// between the synchronized pin and the current debounced value. Accepted
// 0->1 and 1->0 transitions set sticky rise/fall flags. Those flags are
// cleared by writing 1 to them (W1C), and are masked by an interrupt-enable
// register to produce a level interrupt.
//
// Register map (address within the slot):
//   0 : stable  (RO)  debounced pin levels
//   1 : rise    (W1C) sticky rising-edge flags
//   2 : fall    (W1C) sticky falling-edge flags
//   3 : ie      (RW)  interrupt enable mask
//   4..31 reserved: reads return 0, writes are ignored
//
// Ports:
//   clock    : single clock; all state changes on its rising edge
//   reset    : asynchronous, active-high reset
//   address  : register select
//   rd_data  : combinational read data (0 unless read & cs selects a register)
//   wr_data  : write data
//   read     : read strobe (qualified by cs)
//   write    : write strobe (qualified by cs)
//   cs       : slot chip select
//   data_in  : asynchronous external pins
//   irq      : level interrupt, |((rise | fall) & ie)
// -----------------------------------------------------------------------------
module gpi_debounce #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       address,
  output logic [31:0]      rd_data,
  input  logic [31:0]      wr_data,
  input  logic             read,
  input  logic             write,
  input  logic             cs,
  input  logic [WIDTH-1:0] data_in,
  output logic             irq
);

  localparam int CW = (DB_CYCLES + 1 > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [4:0] ADDR_STABLE = 5'd0;
  localparam logic [4:0] ADDR_RISE   = 5'd1;
  localparam logic [4:0] ADDR_FALL   = 5'd2;
  localparam logic [4:0] ADDR_IE     = 5'd3;

  logic             wr_en;
  logic             rd_en;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] ie_q, ie_d;

  // Upper write-data bits beyond WIDTH have no destination.
  logic             unused_wr_data;
  assign unused_wr_data = ^wr_data;

  assign wr_en = write & cs;
  assign rd_en = read & cs;

  // Synchronizer: data_in is asynchronous to clock, so it gets two flops
  // before any logic looks at it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the counter runs only while the synchronized level
  // disagrees with the accepted level. Any agreement restarts it, so a
  // glitch shorter than DB_CYCLES never reaches stable.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Sticky edge flags and interrupt mask. A new edge is ORed in after the
  // W1C clear so that an edge coinciding with a clear is not lost.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    ie_d   = ie_q;
    if (wr_en) begin
      case (address)
        ADDR_RISE: rise_d = rise_q & ~wr_data[WIDTH-1:0];
        ADDR_FALL: fall_d = fall_q & ~wr_data[WIDTH-1:0];
        ADDR_IE:   ie_d   = wr_data[WIDTH-1:0];
        default:   ;
      endcase
    end
    rise_d = rise_d | (stable_d & ~stable_q);
    fall_d = fall_d | (~stable_d & stable_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      ie_q     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      ie_q     <= ie_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (rd_en) begin
      case (address)
        ADDR_STABLE: rd_data = 32'(stable_q);
        ADDR_RISE:   rd_data = 32'(rise_q);
        ADDR_FALL:   rd_data = 32'(fall_q);
        ADDR_IE:     rd_data = 32'(ie_q);
        default:     rd_data = 32'd0;
      endcase
    end
  end

  assign irq = |((rise_q | fall_q) & ie_q);

endmodule

// File: tb/tb_gpi_debounce.sv
module tb_gpi_debounce;

  localparam int WIDTH     = 16;
  localparam int DB_CYCLES = 4;

  logic             clock;
  logic             reset;
  logic [4:0]       address;
  logic [31:0]      rd_data;
  logic [31:0]      wr_data;
  logic             read;
  logic             write;
  logic             cs;
  logic [WIDTH-1:0] data_in;
  logic             irq;

  int checks;
  int failures;

  gpi_debounce #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .rd_data (rd_data),
    .wr_data (wr_data),
    .read    (read),
    .write   (write),
    .cs      (cs),
    .data_in (data_in),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational register read; does not advance the clock.
  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    cs      = 1'b1;
    #1;
    d       = rd_data;
    read    = 1'b0;
    cs      = 1'b0;
  endtask

  // One-cycle write, launched at a falling edge, committed at the next rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a;
    wr_data = d;
    write   = 1'b1;
    cs      = 1'b1;
    @(negedge clock);
    write   = 1'b0;
    cs      = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    #12;
    for (int a = 0; a < 4; a++) begin
      do_read(5'(a), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL reset_rd addr=%0d got=%h want=%h", a, d, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b want=0", irq);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_debounce_rise;
    logic [31:0] d;
    @(negedge clock);
    data_in[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      do_read(5'd0, d);
      checks++;
      if (d !== ((k == 6) ? 32'h1 : 32'h0)) begin
        failures++;
        $display("FAIL rise_latency_stable edge=%0d got=%h want=%h", k, d,
                 (k == 6) ? 32'h1 : 32'h0);
      end
      do_read(5'd1, d);
      checks++;
      if (d !== ((k == 6) ? 32'h1 : 32'h0)) begin
        failures++;
        $display("FAIL rise_latency_flag edge=%0d got=%h want=%h", k, d,
                 (k == 6) ? 32'h1 : 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL rise_irq_masked got=%b want=0", irq);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    logic        bad;
    @(negedge clock);
    data_in[3] = 1'b1;
    repeat (3) @(negedge clock);
    data_in[3] = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (irq !== 1'b0) bad = 1'b1;
      do_read(5'd0, d);
      if (d[3] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL glitch_during got=%b want=0", bad);
    end
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL glitch_stable got=%h want=%h", d, 32'h1);
    end
    do_read(5'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL glitch_rise got=%h want=%h", d, 32'h1);
    end
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL glitch_fall got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_irq_w1c;
    logic [31:0] d;
    do_write(5'd3, 32'h0000_0001);
    do_read(5'd3, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL ie_readback got=%h want=%h", d, 32'h1);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_on_rise got=%b want=1", irq);
    end
    do_write(5'd1, 32'h0000_0001);
    do_read(5'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rise_w1c got=%h want=%h", d, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_after_w1c got=%b want=0", irq);
    end
    do_write(5'd2, 32'h0000_0001);
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL fall_w1c_noop got=%h want=%h", d, 32'h0);
    end
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL stable_after_w1c got=%h want=%h", d, 32'h1);
    end
    // Falling edge on bit 0: fall flag and irq after exactly 6 edges.
    @(negedge clock);
    data_in[0] = 1'b0;
    repeat (5) @(negedge clock);
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL fall_early got=%h want=%h", d, 32'h0);
    end
    @(negedge clock);
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL fall_flag got=%h want=%h", d, 32'h1);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_on_fall got=%b want=1", irq);
    end
    do_write(5'd2, 32'h0000_0002);
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL fall_w1c_other_bit got=%h want=%h", d, 32'h1);
    end
    do_write(5'd2, 32'h0000_0001);
    do_read(5'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL fall_w1c got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    @(negedge clock);
    data_in[2] = 1'b1;
    repeat (5) @(negedge clock);
    // Clear of rise[2] lands on the same edge that stable[2] rises.
    address = 5'd1;
    wr_data = 32'h0000_0004;
    write   = 1'b1;
    cs      = 1'b1;
    @(negedge clock);
    write   = 1'b0;
    cs      = 1'b0;
    do_read(5'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL set_priority_rise got=%h want=%h", d, 32'h4);
    end
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL set_priority_stable got=%h want=%h", d, 32'h4);
    end
    do_write(5'd1, 32'h0000_0004);
    do_read(5'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL rise2_w1c got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_cs_and_reserved;
    logic [31:0] d;
    @(negedge clock);
    address = 5'd3;
    wr_data = 32'h0000_FFFF;
    write   = 1'b1;
    cs      = 1'b0;
    @(negedge clock);
    write   = 1'b0;
    do_read(5'd3, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL cs_low_write got=%h want=%h", d, 32'h1);
    end
    do_read(5'd7, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reserved_read got=%h want=%h", d, 32'h0);
    end
    address = 5'd0;
    read    = 1'b1;
    cs      = 1'b0;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      failures++;
      $display("FAIL cs_low_read got=%h want=%h", rd_data, 32'h0);
    end
    read = 1'b0;
    do_write(5'd0, 32'h0000_0000);
    do_write(5'd9, 32'hFFFF_FFFF);
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL ro_write_stable got=%h want=%h", d, 32'h4);
    end
    do_read(5'd3, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL reserved_write_ie got=%h want=%h", d, 32'h1);
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] d;
    @(negedge clock);
    data_in[5] = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      do_read(5'(a), d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("FAIL async_reset_rd addr=%0d got=%h want=%h", a, d, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_irq got=%b want=0", irq);
    end
    @(negedge clock);
    reset = 1'b0;
    // Pins 2 and 5 held high through reset: accepted exactly 6 edges later.
    repeat (5) @(negedge clock);
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_early got=%h want=%h", d, 32'h0);
    end
    @(negedge clock);
    do_read(5'd0, d);
    checks++;
    if (d !== 32'h24) begin
      failures++;
      $display("FAIL post_reset_stable got=%h want=%h", d, 32'h24);
    end
    do_read(5'd1, d);
    checks++;
    if (d !== 32'h24) begin
      failures++;
      $display("FAIL post_reset_rise got=%h want=%h", d, 32'h24);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_irq got=%b want=0", irq);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    address  = 5'd0;
    wr_data  = 32'd0;
    read     = 1'b0;
    write    = 1'b0;
    cs       = 1'b0;
    data_in  = '0;

    test_reset();
    test_debounce_rise();
    test_glitch();
    test_irq_w1c();
    test_back_to_back();
    test_cs_and_reserved();
    test_reset_midcount();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
